wave_mixer: RTL and testbench

Sums the sample outputs of up to eight `wave_sound` players into one signed 16-bit stream for the audio output path. It sits directly downstream of the `wave_sound` instances, one input per DMA channel, and feeds the codec/DAC interface.
- One multiply-accumulate is time-multiplexed across the channels, one channel per clock, on each output-rate strobe.
- Per-channel volume, enable and 8-bit/16-bit format are supported.
- The summed result is saturated to 16 bits.

---
 rtl/wave_pkg.sv | 14 +
 rtl/wave_mix_mac.sv | 22 ++
 rtl/wave_mixer.sv | 138 +++++++++++++
 tb/tb_wave_mixer.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/wave_pkg.sv
// Shared widths, constants and FSM state encoding for the wave mixer.
package wave_pkg;
    localparam int SMP_W  = 16;
    localparam int VOL_W  = 8;
    localparam int ACC_W  = 20;
    localparam int PROD_W = SMP_W + VOL_W + 1;
    localparam int OFS8   = 128;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACC,
        ST_OUT
    } state_e;
endpackage

// File: rtl/wave_mix_mac.sv
// One channel term: normalise to signed 16, scale by vol/256, gate by enable.
module wave_mix_mac
    import wave_pkg::*;
(
    input  logic [SMP_W-1:0]        d,
    input  logic                    fmt8,
    input  logic [VOL_W-1:0]        vol,
    input  logic                    en,
    output logic signed [ACC_W-1:0] term
);
    logic signed [SMP_W-1:0]  u8_s;
    logic signed [SMP_W-1:0]  s;
    logic signed [PROD_W-1:0] p;

    always_comb begin
        // Unsigned 8-bit centred on 128, then moved up to full 16-bit scale.
        u8_s = signed'({8'b0, d[7:0]}) - SMP_W'(OFS8);
        s    = fmt8 ? (u8_s <<< 8) : signed'(d);
        p    = s * signed'({1'b0, vol});
        term = en ? {{(ACC_W - PROD_W + 8){p[PROD_W-1]}}, p[PROD_W-1:8]} : '0;
    end
endmodule

// File: rtl/wave_mixer.sv
// Time-multiplexed mixer: one channel MAC per clock, saturated 16-bit output per strobe.
module wave_mixer
    import wave_pkg::*;
#(
    parameter int NUM_CHAN    = 8,
    parameter int ATTEN_SHIFT = 0
) (
    input  logic                      I_CLK,
    input  logic                      I_RST,
    input  logic                      I_STROBE,
    input  logic [NUM_CHAN*SMP_W-1:0] I_SND,
    input  logic [NUM_CHAN-1:0]       I_FMT8,
    input  logic [NUM_CHAN*VOL_W-1:0] I_VOL,
    input  logic [NUM_CHAN-1:0]       I_CH_EN,
    output logic [SMP_W-1:0]          O_SND,
    output logic                      O_VALID,
    output logic                      O_CLIP,
    output logic                      O_BUSY,
    output logic                      O_MISS
);
    localparam int IDX_W = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1;
    localparam logic [IDX_W-1:0]        IDX_LAST = IDX_W'(NUM_CHAN - 1);
    localparam logic signed [ACC_W-1:0] SAT_MAX  = ACC_W'(2 ** (SMP_W - 1) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN  = ~SAT_MAX;

    state_e state_q, state_d;

    logic [NUM_CHAN*SMP_W-1:0] snd_q;
    logic [NUM_CHAN-1:0]       fmt_q;
    logic [NUM_CHAN*VOL_W-1:0] vol_q;
    logic [NUM_CHAN-1:0]       en_q;
    logic [IDX_W-1:0]          idx;
    logic signed [ACC_W-1:0]   acc;

    logic [SMP_W-1:0]        ch_snd;
    logic                    ch_fmt8;
    logic [VOL_W-1:0]        ch_vol;
    logic                    ch_en;
    logic signed [ACC_W-1:0] term;
    logic signed [ACC_W-1:0] shifted;
    logic [SMP_W-1:0]        sat_snd;
    logic                    sat_clip;

    always_ff @(posedge I_CLK) begin
        if (I_RST) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (I_STROBE) state_d = ST_ACC;
            ST_ACC:  if (idx == IDX_LAST) state_d = ST_OUT;
            ST_OUT:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign O_BUSY = (state_q != ST_IDLE);

    always_comb begin
        ch_snd  = '0;
        ch_fmt8 = 1'b0;
        ch_vol  = '0;
        ch_en   = 1'b0;
        for (int n = 0; n < NUM_CHAN; n++) begin
            if (idx == IDX_W'(n)) begin
                ch_snd  = snd_q[n*SMP_W +: SMP_W];
                ch_fmt8 = fmt_q[n];
                ch_vol  = vol_q[n*VOL_W +: VOL_W];
                ch_en   = en_q[n];
            end
        end
    end

    wave_mix_mac u_mac (
        .d    (ch_snd),
        .fmt8 (ch_fmt8),
        .vol  (ch_vol),
        .en   (ch_en),
        .term (term)
    );

    always_comb begin
        shifted  = acc >>> ATTEN_SHIFT;
        sat_clip = 1'b0;
        sat_snd  = shifted[SMP_W-1:0];
        if (shifted > SAT_MAX) begin
            sat_snd  = SAT_MAX[SMP_W-1:0];
            sat_clip = 1'b1;
        end else if (shifted < SAT_MIN) begin
            sat_snd  = SAT_MIN[SMP_W-1:0];
            sat_clip = 1'b1;
        end
    end

    always_ff @(posedge I_CLK) begin
        if (I_RST) begin
            snd_q   <= '0;
            fmt_q   <= '0;
            vol_q   <= '0;
            en_q    <= '0;
            idx     <= '0;
            acc     <= '0;
            O_SND   <= '0;
            O_VALID <= 1'b0;
            O_CLIP  <= 1'b0;
            O_MISS  <= 1'b0;
        end else begin
            O_VALID <= 1'b0;
            O_CLIP  <= 1'b0;
            // Strobes landing mid-mix are dropped, only flagged.
            if (I_STROBE && state_q != ST_IDLE) O_MISS <= 1'b1;
            case (state_q)
                ST_IDLE: begin
                    if (I_STROBE) begin
                        snd_q <= I_SND;
                        fmt_q <= I_FMT8;
                        vol_q <= I_VOL;
                        en_q  <= I_CH_EN;
                        acc   <= '0;
                        idx   <= '0;
                    end
                end
                ST_ACC: begin
                    acc <= acc + term;
                    if (idx != IDX_LAST) idx <= idx + 1'b1;
                end
                ST_OUT: begin
                    O_SND   <= sat_snd;
                    O_CLIP  <= sat_clip;
                    O_VALID <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_wave_mixer.sv
// Randomised and directed check of wave_mixer against an arithmetic reference model.
module tb_wave_mixer;
    localparam int NC = 8;

    logic            I_CLK = 1'b0;
    logic            I_RST;
    logic            I_STROBE;
    logic [NC*16-1:0] I_SND;
    logic [NC-1:0]   I_FMT8;
    logic [NC*8-1:0] I_VOL;
    logic [NC-1:0]   I_CH_EN;

    logic [15:0] snd0, snd1;
    logic        vld0, vld1, clip0, clip1, busy0, busy1, miss0, miss1;

    int n_cmp = 0;
    int n_err = 0;
    logic [15:0] exp_snd0, exp_snd1;
    bit          exp_clip0, exp_clip1;

    always #5 I_CLK = ~I_CLK;

    wave_mixer #(.NUM_CHAN(NC), .ATTEN_SHIFT(0)) u_dut (
        .I_CLK(I_CLK), .I_RST(I_RST), .I_STROBE(I_STROBE), .I_SND(I_SND),
        .I_FMT8(I_FMT8), .I_VOL(I_VOL), .I_CH_EN(I_CH_EN),
        .O_SND(snd0), .O_VALID(vld0), .O_CLIP(clip0), .O_BUSY(busy0), .O_MISS(miss0)
    );

    wave_mixer #(.NUM_CHAN(NC), .ATTEN_SHIFT(1)) u_att (
        .I_CLK(I_CLK), .I_RST(I_RST), .I_STROBE(I_STROBE), .I_SND(I_SND),
        .I_FMT8(I_FMT8), .I_VOL(I_VOL), .I_CH_EN(I_CH_EN),
        .O_SND(snd1), .O_VALID(vld1), .O_CLIP(clip1), .O_BUSY(busy1), .O_MISS(miss1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic straight from the mixing rules.
    function automatic void model(input logic [NC*16-1:0] snd, input logic [NC-1:0] f8,
                                  input logic [NC*8-1:0] vl, input logic [NC-1:0] en,
                                  input int sh, output logic [15:0] res, output bit clip);
        int acc, s, r;
        logic [15:0] d;
        acc = 0;
        for (int n = 0; n < NC; n++) begin
            d = snd[16*n +: 16];
            if (f8[n]) s = (int'(d[7:0]) - 128) * 256;
            else       s = int'($signed(d));
            if (en[n]) acc += (s * int'(vl[8*n +: 8])) >>> 8;
        end
        r = acc >>> sh;
        clip = 1'b0;
        if (r > 32767)  begin r = 32767;  clip = 1'b1; end
        if (r < -32768) begin r = -32768; clip = 1'b1; end
        res = r[15:0];
    endfunction

    task automatic clear_all();
        I_SND = '0; I_FMT8 = '0; I_VOL = '0; I_CH_EN = '0;
    endtask

    task automatic set_ch(input int n, input logic [15:0] d, input bit f, input logic [7:0] v, input bit e);
        I_SND[16*n +: 16] = d;
        I_FMT8[n]         = f;
        I_VOL[8*n +: 8]   = v;
        I_CH_EN[n]        = e;
    endtask

    task automatic randomise();
        for (int n = 0; n < NC; n++) begin
            I_SND[16*n +: 16] = 16'($urandom);
            I_FMT8[n]         = 1'($urandom);
            I_VOL[8*n +: 8]   = 8'($urandom);
            I_CH_EN[n]        = 1'($urandom);
        end
        if ($urandom_range(0, 3) == 0) I_VOL = '1;
    endtask

    // Caller sits at a negedge; strobe is sampled on the following posedge.
    task automatic start_mix();
        model(I_SND, I_FMT8, I_VOL, I_CH_EN, 0, exp_snd0, exp_clip0);
        model(I_SND, I_FMT8, I_VOL, I_CH_EN, 1, exp_snd1, exp_clip1);
        I_STROBE = 1'b1;
    endtask

    // Returns at the negedge on which O_VALID is observed (or on timeout).
    task automatic finish_mix(input string tag);
        int lat;
        lat = 0;
        @(posedge I_CLK);
        while (lat < 30) begin
            @(negedge I_CLK);
            lat++;
            if (lat == 1) begin
                I_STROBE = 1'b0;
                chk({tag, ".busy"}, 32'(busy0), 32'd1);
            end
            if (vld0) break;
        end
        chk({tag, ".lat"},   32'(lat),   32'(NC + 2));
        chk({tag, ".snd0"},  32'(snd0),  32'(exp_snd0));
        chk({tag, ".clip0"}, 32'(clip0), 32'(exp_clip0));
        chk({tag, ".vld1"},  32'(vld1),  32'd1);
        chk({tag, ".snd1"},  32'(snd1),  32'(exp_snd1));
        chk({tag, ".clip1"}, 32'(clip1), 32'(exp_clip1));
        chk({tag, ".idle"},  32'(busy0), 32'd0);
    endtask

    task automatic run_mix(input string tag);
        @(negedge I_CLK);
        start_mix();
        finish_mix(tag);
    endtask

    initial begin
        int nv;
        I_RST = 1'b1; I_STROBE = 1'b0;
        clear_all();
        repeat (2) @(posedge I_CLK);
        @(negedge I_CLK);
        chk("rst.snd",  32'(snd0),  32'd0);
        chk("rst.vld",  32'(vld0),  32'd0);
        chk("rst.clip", 32'(clip0), 32'd0);
        chk("rst.busy", 32'(busy0), 32'd0);
        chk("rst.miss", 32'(miss0), 32'd0);
        I_RST = 1'b0;

        clear_all(); set_ch(0, 16'h4000, 0, 8'd128, 1);
        run_mix("single");
        chk("single.val", 32'(snd0), 32'h2000);

        clear_all(); set_ch(0, 16'h00FF, 1, 8'd128, 1);
        run_mix("fmt8ff");
        chk("fmt8ff.val", 32'(snd0), 32'd16256);
        set_ch(0, 16'h0080, 1, 8'd128, 1);
        run_mix("fmt880");

        for (int n = 0; n < NC; n++) set_ch(n, 16'h7FFF, 0, 8'd255, 1);
        run_mix("satpos");
        chk("satpos.val", 32'({clip0, snd0}), 32'h17FFF);
        for (int n = 0; n < NC; n++) set_ch(n, 16'h8000, 0, 8'd255, 1);
        run_mix("satneg");
        chk("satneg.val", 32'({clip0, snd0}), 32'h18000);

        clear_all();
        set_ch(0, 16'd1000, 0, 8'd255, 1);
        set_ch(1, 16'($signed(-3000)), 0, 8'd255, 0);
        run_mix("endis");
        chk("endis.val", 32'(snd0), 32'd996);
        I_CH_EN[1] = 1'b1;
        run_mix("enatt");

        // Random mixes; odd iterations strobe in the O_VALID cycle itself.
        for (int i = 0; i < 24; i++) begin
            randomise();
            if (i % 2 == 1) begin
                start_mix();
                finish_mix("rand_b2b");
            end else begin
                repeat ($urandom_range(0, 3)) @(negedge I_CLK);
                run_mix("rand");
            end
        end
        @(negedge I_CLK);
        chk("vld.pulse", 32'(vld0), 32'd0);
        chk("b2b.miss",  32'(miss0), 32'd0);

        // Colliding strobe plus input change after the snapshot.
        randomise();
        @(negedge I_CLK);
        start_mix();
        @(posedge I_CLK);
        @(negedge I_CLK);
        I_STROBE = 1'b0;
        randomise();
        @(negedge I_CLK);
        @(negedge I_CLK);
        I_STROBE = 1'b1;
        @(negedge I_CLK);
        I_STROBE = 1'b0;
        nv = 0;
        for (int i = 0; i < 16; i++) begin
            if (vld0) begin
                nv++;
                chk("coll.snd0", 32'(snd0), 32'(exp_snd0));
                chk("coll.snd1", 32'(snd1), 32'(exp_snd1));
            end
            @(negedge I_CLK);
        end
        chk("coll.nvalid", 32'(nv),    32'd1);
        chk("coll.miss",   32'(miss0), 32'd1);
        randomise();
        run_mix("post_coll");
        chk("coll.miss_sticky", 32'(miss0), 32'd1);

        // Reset asserted so it is sampled on the 4th ACC edge.
        clear_all(); set_ch(2, 16'h1234, 0, 8'd200, 1);
        @(negedge I_CLK);
        start_mix();
        @(posedge I_CLK);
        @(negedge I_CLK);
        I_STROBE = 1'b0;
        repeat (3) @(negedge I_CLK);
        I_RST = 1'b1;
        @(negedge I_CLK);
        I_RST = 1'b0;
        chk("mrst.busy", 32'(busy0), 32'd0);
        chk("mrst.snd",  32'(snd0),  32'd0);
        chk("mrst.miss", 32'(miss0), 32'd0);
        nv = 0;
        for (int i = 0; i < 12; i++) begin
            if (vld0) nv++;
            @(negedge I_CLK);
        end
        chk("mrst.novalid", 32'(nv), 32'd0);
        randomise();
        run_mix("after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
